// File: rtl/rsp_s2_prep_pkg.sv
// Shared types and constant helpers for the S2 prep phase-rotation stage.
// Holds the sample/twiddle structs, the frame FSM encoding and round/saturate constants.
`timescale 1ns/1ps
package rsp_s2_prep_pkg;

  localparam int IQ_W      = 16;
  localparam int TW_COMP_W = 32;

  typedef struct packed {
    logic signed [IQ_W-1:0] i;
    logic signed [IQ_W-1:0] q;
  } iq_t;

  typedef struct packed {
    logic signed [TW_COMP_W-1:0] re;
    logic signed [TW_COMP_W-1:0] im;
  } twiddle_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } frame_state_t;

  function automatic longint sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  function automatic longint round_bias(input int frac);
    return 64'sd1 <<< (frac - 1);
  endfunction

endpackage

// File: rtl/rsp_s2_prep_pg_phase_rotate_if.sv
// Sample stream bundle (valid/last/data) used on both sides of the rotation stage.
`timescale 1ns/1ps
interface rsp_s2_prep_pg_phase_rotate_if #(
  parameter int IQ_WIDTH = 16
);
  logic                    valid;
  logic                    last;
  logic [2*IQ_WIDTH-1:0]   data;

  modport master (output valid, output last, output data);
  modport slave  (input  valid, input  last, input  data);
endinterface

// File: rtl/rsp_s2_prep_cmult.sv
// Three-stage complex multiplier (products, sum/difference, round+saturate) with valid/last.
// RSP_S2_PREP_ROT_CONJ_EN selects multiplication by the conjugate twiddle.
`timescale 1ns/1ps
module rsp_s2_prep_cmult
  import rsp_s2_prep_pkg::*;
#(
  parameter int IQ_WIDTH = 16,
  parameter int TW_FRAC  = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [2*IQ_WIDTH-1:0] in_data,
  input  twiddle_t              twiddle,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [2*IQ_WIDTH-1:0] out_data,
  output logic                  busy
);

  localparam int PROD_W = IQ_WIDTH + TW_COMP_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam logic signed [SUM_W-1:0] BIAS    = SUM_W'(round_bias(TW_FRAC));
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(sat_max(IQ_WIDTH));
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(sat_min(IQ_WIDTH));

  logic signed [IQ_WIDTH-1:0] s_i;
  logic signed [IQ_WIDTH-1:0] s_q;
  assign s_i = $signed(in_data[2*IQ_WIDTH-1:IQ_WIDTH]);
  assign s_q = $signed(in_data[IQ_WIDTH-1:0]);

  logic signed [PROD_W-1:0] p_iwr_reg, p_qwi_reg, p_iwi_reg, p_qwr_reg;
  logic                     m1_valid_reg, m1_last_reg;
  logic signed [SUM_W-1:0]  re_reg, im_reg;
  logic                     m2_valid_reg, m2_last_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_iwr_reg    <= '0;
      p_qwi_reg    <= '0;
      p_iwi_reg    <= '0;
      p_qwr_reg    <= '0;
      m1_valid_reg <= 1'b0;
      m1_last_reg  <= 1'b0;
    end else begin
      p_iwr_reg    <= PROD_W'(s_i) * PROD_W'($signed(twiddle.re));
      p_qwi_reg    <= PROD_W'(s_q) * PROD_W'($signed(twiddle.im));
      p_iwi_reg    <= PROD_W'(s_i) * PROD_W'($signed(twiddle.im));
      p_qwr_reg    <= PROD_W'(s_q) * PROD_W'($signed(twiddle.re));
      m1_valid_reg <= in_valid;
      m1_last_reg  <= in_last;
    end
  end

  // Conjugation is folded into the add/subtract signs so a -2^31 imag part cannot overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_reg       <= '0;
      im_reg       <= '0;
      m2_valid_reg <= 1'b0;
      m2_last_reg  <= 1'b0;
    end else begin
`ifdef RSP_S2_PREP_ROT_CONJ_EN
      re_reg <= SUM_W'(p_iwr_reg) + SUM_W'(p_qwi_reg);
      im_reg <= SUM_W'(p_qwr_reg) - SUM_W'(p_iwi_reg);
`else
      re_reg <= SUM_W'(p_iwr_reg) - SUM_W'(p_qwi_reg);
      im_reg <= SUM_W'(p_iwi_reg) + SUM_W'(p_qwr_reg);
`endif
      m2_valid_reg <= m1_valid_reg;
      m2_last_reg  <= m1_last_reg;
    end
  end

  function automatic logic [IQ_WIDTH-1:0] round_sat(input logic signed [SUM_W-1:0] x);
    logic signed [SUM_W-1:0] r;
    r = (x + BIAS) >>> TW_FRAC;
    if (r > SAT_MAX) begin
      return SAT_MAX[IQ_WIDTH-1:0];
    end else if (r < SAT_MIN) begin
      return SAT_MIN[IQ_WIDTH-1:0];
    end
    return r[IQ_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_data  <= {round_sat(re_reg), round_sat(im_reg)};
      out_valid <= m2_valid_reg;
      out_last  <= m2_last_reg;
    end
  end

  assign busy = m1_valid_reg | m2_valid_reg;

endmodule

// File: rtl/rsp_s2_prep_pg_phase_rotate.sv
// Phase-rotation stage: aligns samples with the generator twiddle, rotates, and polices frame length.
// Build option RSP_S2_PREP_ROT_CONJ_EN switches the multiplier to de-rotation (conjugate twiddle).
`timescale 1ns/1ps
module rsp_s2_prep_pg_phase_rotate
  import rsp_s2_prep_pkg::*;
#(
  parameter int IQ_WIDTH      = 16,
  parameter int TWIDDLE_WIDTH = 64,
  parameter int TW_FRAC       = 30,
  parameter int TW_LAT        = 4,
  parameter int DATA_NUM      = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  rsp_s2_prep_pg_phase_rotate_if.slave  sample_in,
  input  logic [TWIDDLE_WIDTH-1:0]      i_phase_w,
  rsp_s2_prep_pg_phase_rotate_if.master sample_out,
  output logic                          o_frame_err,
  output logic                          o_busy
);

  localparam int CNT_W = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_NUM - 1);

  frame_state_t     state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             err_reg, err_next;
  logic             in_frame;
  logic             head_last;

  // A simultaneous start makes the sample part of the new frame.
  assign in_frame  = i_start || (state_reg == RUN);
  assign head_last = sample_in.valid && sample_in.last && in_frame;

  logic [TW_LAT-1:0]                     align_valid;
  logic [TW_LAT-1:0]                     align_last;
  logic [TW_LAT-1:0][2*IQ_WIDTH-1:0]     align_data;

  genvar gi;
  generate
    for (gi = 0; gi < TW_LAT; gi++) begin : g_align
      logic                  valid_reg, last_reg;
      logic [2*IQ_WIDTH-1:0] data_reg;
      logic                  valid_d, last_d;
      logic [2*IQ_WIDTH-1:0] data_d;

      if (gi == 0) begin : g_head
        assign valid_d = sample_in.valid;
        assign last_d  = head_last;
        assign data_d  = sample_in.data;
      end else begin : g_link
        assign valid_d = align_valid[gi-1];
        assign last_d  = align_last[gi-1];
        assign data_d  = align_data[gi-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg <= 1'b0;
          last_reg  <= 1'b0;
          data_reg  <= '0;
        end else begin
          valid_reg <= valid_d;
          last_reg  <= last_d;
          data_reg  <= data_d;
        end
      end

      assign align_valid[gi] = valid_reg;
      assign align_last[gi]  = last_reg;
      assign align_data[gi]  = data_reg;
    end
  endgenerate

  twiddle_t twiddle;
  logic     cmult_busy;
  assign twiddle = twiddle_t'(i_phase_w);

  rsp_s2_prep_cmult #(
    .IQ_WIDTH (IQ_WIDTH),
    .TW_FRAC  (TW_FRAC)
  ) u_cmult (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (align_valid[TW_LAT-1]),
    .in_last   (align_last[TW_LAT-1]),
    .in_data   (align_data[TW_LAT-1]),
    .twiddle   (twiddle),
    .out_valid (sample_out.valid),
    .out_last  (sample_out.last),
    .out_data  (sample_out.data),
    .busy      (cmult_busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    err_next   = err_reg;
    if (i_start) begin
      state_next = RUN;
      count_next = '0;
      err_next   = 1'b0;
    end
    if (sample_in.valid) begin
      if (in_frame) begin
        if (sample_in.last) begin
          state_next = IDLE;
          if (count_next != CNT_MAX) err_next = 1'b1;
        end else if (count_next == CNT_MAX) begin
          err_next = 1'b1;
        end
        if (count_next != CNT_MAX) count_next = count_next + CNT_W'(1);
      end else begin
        err_next = 1'b1;
      end
    end
  end

  assign o_frame_err = err_reg;
  assign o_busy      = (state_reg == RUN) || (|align_valid) || cmult_busy;

endmodule

// File: tb/tb_rsp_s2_prep_pg_phase_rotate.sv
// Directed bench for the phase-rotation stage: scoreboard of expected outputs plus frame-error checks.
`timescale 1ns/1ps
module tb_rsp_s2_prep_pg_phase_rotate;
  import rsp_s2_prep_pkg::*;

  localparam int TW_LAT   = 4;
  localparam int LAT      = TW_LAT + 3;
  localparam int DATA_NUM = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [63:0] i_phase_w = '0;
  logic        o_frame_err;
  logic        o_busy;

  rsp_s2_prep_pg_phase_rotate_if #(.IQ_WIDTH(16)) in_if ();
  rsp_s2_prep_pg_phase_rotate_if #(.IQ_WIDTH(16)) out_if ();

  rsp_s2_prep_pg_phase_rotate #(
    .IQ_WIDTH      (16),
    .TWIDDLE_WIDTH (64),
    .TW_FRAC       (30),
    .TW_LAT        (TW_LAT),
    .DATA_NUM      (DATA_NUM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .sample_in   (in_if.slave),
    .i_phase_w   (i_phase_w),
    .sample_out  (out_if.master),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    longint      cyc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  longint      cyc = 0;
  int          out_cnt = 0;
  logic        seen_last = 1'b0;
  logic [63:0] tw_hist [TW_LAT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] d, input logic [63:0] w);
    iq_t    s;
    longint si, sq, wr, wi, re, im;
    s  = d;
    si = longint'(s.i);
    sq = longint'(s.q);
    wr = longint'($signed(w[63:32]));
    wi = longint'($signed(w[31:0]));
`ifdef RSP_S2_PREP_ROT_CONJ_EN
    re = si * wr + sq * wi;
    im = sq * wr - si * wi;
`else
    re = si * wr - sq * wi;
    im = si * wi + sq * wr;
`endif
    re = sat16((re + (64'sd1 <<< 29)) >>> 30);
    im = sat16((im + (64'sd1 <<< 29)) >>> 30);
    return {re[15:0], im[15:0]};
  endfunction

  function automatic logic [63:0] rand_tw();
    longint wr, wi;
    wr = longint'($urandom_range(0, 32'h8000_0000)) - 64'sd1073741824;
    wi = longint'($urandom_range(0, 32'h8000_0000)) - 64'sd1073741824;
    return {wr[31:0], wi[31:0]};
  endfunction

  // Twiddle for a sample is presented TW_LAT cycles after the sample itself.
  task automatic drive(input logic st, input logic v, input logic l,
                       input logic [31:0] d, input logic [63:0] w);
    i_start     = st;
    in_if.valid = v;
    in_if.last  = l;
    in_if.data  = d;
    i_phase_w   = tw_hist[TW_LAT-1];
    for (int k = TW_LAT - 1; k > 0; k--) tw_hist[k] = tw_hist[k-1];
    tw_hist[0] = w;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic st, input logic l, input logic exp_last,
                      input logic [31:0] d, input logic [63:0] w, input logic [31:0] exp_d);
    exp_t e;
    e.data = exp_d;
    e.last = exp_last;
    e.cyc  = cyc + LAT;
    sb.push_back(e);
    drive(st, 1'b1, l, d, w);
  endtask

  task automatic send_rand(input logic st, input logic l, input logic exp_last);
    logic [31:0] d;
    logic [63:0] w;
    d = $urandom;
    w = rand_tw();
    send(st, l, exp_last, d, w, model(d, w));
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_if.valid) begin
      out_cnt++;
      if (out_if.last) seen_last = 1'b1;
      $display("[TB] out #%0d cyc=%0d data=%h last=%b", out_cnt, cyc, out_if.data, out_if.last);
      if (sb.size() == 0) begin
        check("stray_valid", 64'(out_if.valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", 64'(out_if.data), 64'(e.data));
        check("out_last", 64'(out_if.last), 64'(e.last));
        check("latency_cyc", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    int          cnt0;
    logic [31:0] exp_j;
    foreach (tw_hist[k]) tw_hist[k] = '0;
    in_if.valid = 1'b0;
    in_if.last  = 1'b0;
    in_if.data  = '0;

    #2;
    check("rst_valid", 64'(out_if.valid), 64'd0);
    check("rst_last",  64'(out_if.last),  64'd0);
    check("rst_data",  64'(out_if.data),  64'd0);
    check("rst_err",   64'(o_frame_err),  64'd0);
    check("rst_busy",  64'(o_busy),       64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Stray sample in IDLE: passes with last forced low and flags an error.
    send(1'b0, 1'b1, 1'b0, 32'h1234_5678, 64'h4000_0000_0000_0000, 32'h1234_5678);
    check("stray_err", 64'(o_frame_err), 64'd1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
    check("start_clr_err", 64'(o_frame_err), 64'd0);
    check("run_busy", 64'(o_busy), 64'd1);

    // Directed datapath points.
`ifdef RSP_S2_PREP_ROT_CONJ_EN
    exp_j = {16'd0, 16'hC000};
`else
    exp_j = {16'd0, 16'd16384};
`endif
    send(1'b0, 1'b0, 1'b0, {16'd16384, 16'd0}, {32'h4000_0000, 32'h0}, {16'd16384, 16'd0});
    send(1'b0, 1'b0, 1'b0, {16'd16384, 16'd0}, {32'h0, 32'h4000_0000}, exp_j);
    send(1'b0, 1'b0, 1'b0, {16'h8000, 16'd0},  {32'hC000_0000, 32'h0}, {16'h7FFF, 16'd0});
    send(1'b0, 1'b0, 1'b0, {16'd1, 16'd0},     {32'h2000_0000, 32'h0}, {16'd1, 16'd0});
    idle(10);

    // Short frame: last on sample 5.
    send_rand(1'b1, 1'b0, 1'b0);
    send_rand(1'b0, 1'b0, 1'b0);
    send_rand(1'b0, 1'b0, 1'b0);
    send_rand(1'b0, 1'b0, 1'b0);
    check("short_err_pre", 64'(o_frame_err), 64'd0);
    send_rand(1'b0, 1'b1, 1'b1);
    check("short_err", 64'(o_frame_err), 64'd1);
    idle(3);
    check("short_err_hold", 64'(o_frame_err), 64'd1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
    check("short_err_clr", 64'(o_frame_err), 64'd0);
    idle(LAT + 2);

    // Full frame, start coincident with the first sample.
    seen_last = 1'b0;
    cnt0 = out_cnt;
    for (int k = 0; k < DATA_NUM; k++) begin
      send_rand((k == 0), (k == DATA_NUM - 1), (k == DATA_NUM - 1));
    end
    check("full_err", 64'(o_frame_err), 64'd0);
    idle(LAT - 2);
    check("full_busy_hi", 64'(o_busy), 64'd1);
    idle(1);
    check("full_busy_lo", 64'(o_busy), 64'd0);
    idle(2);
    check("full_out_cnt", 64'(out_cnt - cnt0), 64'(DATA_NUM));
    check("full_seen_last", 64'(seen_last), 64'd1);

    // Overlong frame: the sample after DATA_NUM-1 without last is the offender.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
    for (int k = 0; k < DATA_NUM - 1; k++) send_rand(1'b0, 1'b0, 1'b0);
    check("long_err_pre", 64'(o_frame_err), 64'd0);
    send_rand(1'b0, 1'b0, 1'b0);
    check("long_err", 64'(o_frame_err), 64'd1);
    send_rand(1'b0, 1'b1, 1'b1);
    check("long_err_hold", 64'(o_frame_err), 64'd1);
    idle(LAT + 2);
    check("long_busy_lo", 64'(o_busy), 64'd0);

    // Reset mid-frame after 100 samples.
    for (int k = 0; k < 100; k++) send_rand((k == 0), 1'b0, 1'b0);
    rst = 1'b1;
    in_if.valid = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_if.valid), 64'd0);
    check("mid_rst_data",  64'(out_if.data),  64'd0);
    check("mid_rst_last",  64'(out_if.last),  64'd0);
    check("mid_rst_busy",  64'(o_busy),       64'd0);
    sb.delete();
    idle(2);
    rst = 1'b0;
    cnt0 = out_cnt;
    idle(LAT + 5);
    check("post_rst_no_out", 64'(out_cnt - cnt0), 64'd0);
    check("post_rst_err", 64'(o_frame_err), 64'd0);

    // One-sample frame after reset: last passes, length error flagged.
    send(1'b1, 1'b1, 1'b1, {16'd16384, 16'd0}, {32'h4000_0000, 32'h0}, {16'd16384, 16'd0});
    check("one_frame_err", 64'(o_frame_err), 64'd1);
    idle(LAT + 3);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
